// File: rtl/pipe_skid_reg_pkg.sv
// ---------------------------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared pipeline definitions for the stage-boundary skid registers.
//   - skid_state_e     : occupancy state of a skid stage (empty / main only / main + skid).
//   - PipeDataW        : default MEM/WB payload width
//                        (WB ctrl 2 + ALU out 32 + DM data 32 + rd 5 + instruction 32).
//   - state_occupancy(): number of held entries for a given state.
// ---------------------------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    localparam int unsigned PipeWbCtrlW = 2;
    localparam int unsigned PipeAluW    = 32;
    localparam int unsigned PipeDmW     = 32;
    localparam int unsigned PipeRdW     = 5;
    localparam int unsigned PipeInstrW  = 32;

    localparam int unsigned PipeDataW = PipeWbCtrlW + PipeAluW + PipeDmW + PipeRdW + PipeInstrW;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    function automatic logic [1:0] state_occupancy(input skid_state_e state);
        logic [1:0] occ;
        unique case (state)
            StEmpty: occ = 2'd0;
            StBusy:  occ = 2'd1;
            StFull:  occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------------------------
// pipe_skid_reg
//   Valid/ready pipeline boundary register with a one-entry skid buffer. Accepts one entry per
//   cycle while the downstream keeps up; when the downstream stalls, one extra entry is parked
//   in the skid register so in_ready can be fully registered (no path from out_ready).
//
// Parameters
//   DATA_W        payload width in bits.
//   CLR_ON_FLUSH  1: flush zeroes both payload registers; 0: payload registers keep contents.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   flush      in   synchronous discard of all held entries (beats every transfer)
//   in_valid   in   upstream offers in_data
//   in_data    in   upstream payload
//   in_ready   out  stage accepts in_data this cycle (registered)
//   out_valid  out  out_data holds a valid entry (registered)
//   out_data   out  downstream payload (registered, the main register)
//   out_ready  in   downstream consumes out_data this cycle
//   occupancy  out  number of held entries, 0..2 (registered)
// ---------------------------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_W       = PipeDataW,
    parameter bit          CLR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        occ_q, occ_d;

    logic in_xfer;
    logic out_xfer;

    // Handshakes use only registered flags, so in_ready never depends on out_ready.
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = StEmpty;
            if (CLR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_d  = in_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    unique case ({in_xfer, out_xfer})
                        2'b11: main_d = in_data;
                        2'b01: state_d = StEmpty;
                        2'b10: begin
                            // Downstream stalled: park the new entry behind the main one.
                            skid_d  = in_data;
                            state_d = StFull;
                        end
                        default: ;
                    endcase
                end
                StFull: begin
                    // in_ready is low here, so only the drain of the main entry can happen.
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        // Outputs are registered copies decoded from the next state.
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
        occ_d       = state_occupancy(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int unsigned DW = 103;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    occupancy;

    int n_checks = 0;
    int n_err    = 0;

    // Scoreboard: entries accepted by the stage, oldest first.
    logic [DW-1:0] sb_q[$];
    // Main register is known to be zero (after reset/flush, before the next acceptance).
    bit            exp_zero;

    pipe_skid_reg #(
        .DATA_W      (DW),
        .CLR_ON_FLUSH(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int unsigned cnt;
        cnt = sb_q.size();
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(cnt < 2));
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(cnt != 0));
        chk({tag, ".occupancy"}, 128'(occupancy), 128'(cnt));
        if (cnt != 0) chk({tag, ".out_data"}, 128'(out_data), 128'(sb_q[0]));
        else if (exp_zero) chk({tag, ".out_data_zero"}, 128'(out_data), 128'(0));
    endtask

    // One clock: check at the falling edge, predict transfers, update the model after the edge.
    task automatic tick(input string tag);
        bit            in_x;
        bit            out_x;
        bit            hold;
        logic [DW-1:0] hold_val;
        @(negedge clk);
        check_outputs(tag);
        in_x     = in_valid && (sb_q.size() < 2) && !flush;
        out_x    = (sb_q.size() > 0) && out_ready && !flush;
        hold     = (sb_q.size() > 0) && !out_ready && !flush;
        hold_val = (sb_q.size() > 0) ? sb_q[0] : '0;
        @(posedge clk);
        #1;
        if (flush) begin
            sb_q.delete();
            exp_zero = 1'b1;
        end else begin
            if (out_x) void'(sb_q.pop_front());
            if (in_x) begin
                sb_q.push_back(in_data);
                exp_zero = 1'b0;
            end
        end
        if (hold) begin
            chk({tag, ".hold_valid"}, 128'(out_valid), 128'(1));
            chk({tag, ".hold_data"}, 128'(out_data), 128'(hold_val));
        end
    endtask

    initial begin
        logic [127:0] rnd;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        exp_zero  = 1'b1;

        // Reset values while rst is held.
        #3;
        chk("reset.out_valid", 128'(out_valid), 128'(0));
        chk("reset.in_ready", 128'(in_ready), 128'(1));
        chk("reset.occupancy", 128'(occupancy), 128'(0));
        chk("reset.out_data", 128'(out_data), 128'(0));
        chk("reset.skid", 128'(dut.skid_q), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single entry, first edge after reset.
        in_valid  = 1'b1;
        in_data   = DW'(103'h1A5);
        out_ready = 1'b1;
        tick("single");
        chk("single.out_valid", 128'(out_valid), 128'(1));
        chk("single.out_data", 128'(out_data), 128'(103'h1A5));
        chk("single.occupancy", 128'(occupancy), 128'(1));

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            in_data = DW'(i);
            tick("stream");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick("stream_drain");

        // Backpressure fills the skid register.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(103'hA);
        tick("bp_push_a");
        in_data = DW'(103'hB);
        tick("bp_push_b");
        in_data = DW'(103'hF);  // offered while full, must be ignored
        tick("bp_full");
        chk("bp.occupancy", 128'(occupancy), 128'(2));
        chk("bp.in_ready", 128'(in_ready), 128'(0));
        chk("bp.out_data", 128'(out_data), 128'(103'hA));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick("bp_pop_a");
        chk("bp.second", 128'(out_data), 128'(103'hB));
        tick("bp_pop_b");
        tick("bp_empty");

        // Flush while full beats the same-cycle input and output transfers.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(103'hC);
        tick("fl_push_c");
        in_data = DW'(103'hD);
        tick("fl_push_d");
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = DW'(103'hE);
        tick("fl_flush");
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush.out_valid", 128'(out_valid), 128'(0));
        chk("flush.out_data", 128'(out_data), 128'(0));
        chk("flush.occupancy", 128'(occupancy), 128'(0));
        for (int i = 0; i < 3; i++) tick("fl_after");

        // Asynchronous reset while full, between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(103'h11);
        tick("ar_push1");
        in_data = DW'(103'h22);
        tick("ar_push2");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 128'(out_valid), 128'(0));
        chk("arst.in_ready", 128'(in_ready), 128'(1));
        chk("arst.occupancy", 128'(occupancy), 128'(0));
        chk("arst.out_data", 128'(out_data), 128'(0));
        sb_q.delete();
        exp_zero = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = DW'(103'h33);
        tick("ar_first");
        chk("arst.first_xfer", 128'(out_data), 128'(103'h33));
        in_valid = 1'b0;
        tick("ar_drain");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 10000; i++) begin
            rnd       = {$urandom, $urandom, $urandom, $urandom};
            in_data   = rnd[DW-1:0];
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 50);
            flush     = ($urandom_range(0, 999) == 0);
            tick("rand");
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick("final_drain");
        chk("final.occupancy", 128'(occupancy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
